// File: rtl/bcd_dec_arbiter_if.sv
// Handshake bundle between BCD requesters, the shared decoder arbiter and the
// downstream display consumer.
interface bcd_dec_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] code;
   logic [NREQ-1:0]   ack;
   logic [9:0]        dec_out;
   logic              dec_err;
   logic [IDW-1:0]    dec_id;
   logic              dec_valid;
   logic              dec_ready;

   // master: requesters plus downstream consumer; slave: the arbiter itself
   modport master (
      output req, code, dec_ready,
      input  ack, dec_out, dec_err, dec_id, dec_valid
   );

   modport slave (
      input  req, code, dec_ready,
      output ack, dec_out, dec_err, dec_id, dec_valid
   );
endinterface

// File: rtl/bcd_dec_arbiter.sv
// Round-robin arbiter sharing one BCD-to-1-of-10 decoder between NREQ requesters;
// results leave under valid/ready, invalid codes are flagged and counted.
module bcd_dec_arbiter #(
   parameter int NREQ      = 4,
   parameter int IDW       = $clog2(NREQ),
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_dec_arbiter_if.slave     bus,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [IDW-1:0]       LAST_ID = IDW'(NREQ - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   state_t               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [3:0]           code_q, code_d;
   logic [NREQ-1:0]      ack_q, ack_d;
   logic [9:0]           dec_out_q, dec_out_d;
   logic                 dec_err_q, dec_err_d;
   logic [IDW-1:0]       dec_id_q, dec_id_d;
   logic                 dec_valid_q, dec_valid_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 busy_q, busy_d;

   logic [3:0]           code_lane [NREQ];
   logic                 sel_found;
   logic [IDW-1:0]       sel_idx;
   int                   lane;
   logic [9:0]           onehot;
   logic                 code_bad;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_lane
         assign code_lane[gi] = bus.code[4*gi +: 4];
      end
      // Codes 10..15 match no bit, so the invalid case decodes to all zeros
      for (gi = 0; gi < 10; gi++) begin : g_onehot
         assign onehot[gi] = (code_q == 4'(gi));
      end
   endgenerate

   assign code_bad = (code_q > 4'd9);

   // Scan from the far end back to ptr so the lane closest to ptr wins
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      lane      = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         lane = int'(ptr_q) + k;
         if (lane >= NREQ) begin
            lane = lane - NREQ;
         end
         if (bus.req[lane]) begin
            sel_found = 1'b1;
            sel_idx   = lane[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      code_d      = code_q;
      ack_d       = ack_q;
      dec_out_d   = dec_out_q;
      dec_err_d   = dec_err_q;
      dec_id_d    = dec_id_q;
      dec_valid_d = dec_valid_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               code_d  = code_lane[sel_idx];
               id_d    = sel_idx;
               ack_d   = NREQ'(1) << sel_idx;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ack_d       = '0;
            dec_out_d   = onehot;
            dec_err_d   = code_bad;
            dec_id_d    = id_q;
            dec_valid_d = 1'b1;
            if (code_bad && (err_cnt_q != ERR_MAX)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.dec_ready) begin
               dec_valid_d = 1'b0;
               dec_out_d   = '0;
               dec_err_d   = 1'b0;
               dec_id_d    = '0;
               ptr_d       = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
               state_d     = ST_IDLE;
            end
         end
         default: begin
            ack_d       = '0;
            dec_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         code_q      <= '0;
         ack_q       <= '0;
         dec_out_q   <= '0;
         dec_err_q   <= 1'b0;
         dec_id_q    <= '0;
         dec_valid_q <= 1'b0;
         err_cnt_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         code_q      <= code_d;
         ack_q       <= ack_d;
         dec_out_q   <= dec_out_d;
         dec_err_q   <= dec_err_d;
         dec_id_q    <= dec_id_d;
         dec_valid_q <= dec_valid_d;
         err_cnt_q   <= err_cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.dec_out   = dec_out_q;
   assign bus.dec_err   = dec_err_q;
   assign bus.dec_id    = dec_id_q;
   assign bus.dec_valid = dec_valid_q;
   assign err_cnt       = err_cnt_q;
   assign busy          = busy_q;
endmodule
